// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV64 multicycle control FSM: state enum, opcode classes,
// datapath select codes, error codes and the bundle of decoded control outputs.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;

  typedef enum logic [1:0] {
    IMM_I    = 2'b00,
    IMM_S    = 2'b01,
    IMM_NONE = 2'b10
  } imm_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_IMEM    = 2'b10,
    ERR_DMEM    = 2'b11
  } err_e;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       mdr_we;
    logic [1:0] imm_sel;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       wb_sel;
    logic       rf_we;
    logic       pc_we;
  } ctrl_out_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_I) || (op == OP_L) || (op == OP_S) || (op == OP_R);
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_L) || (op == OP_S);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle controller and the datapath/memories.
interface multicycle_ctrl_if;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       imem_ack_i;
  logic       dmem_ack_i;
  logic       imem_req_o;
  logic       dmem_req_o;
  logic       dmem_we_o;
  logic       ir_we_o;
  logic       mdr_we_o;
  logic [1:0] imm_sel_o;
  logic       alu_src_b_o;
  logic [1:0] alu_op_o;
  logic       wb_sel_o;
  logic       rf_we_o;
  logic       pc_we_o;
  logic [1:0] err_o;

  // Controller side.
  modport master (
    input  opcode_i, funct3_i, funct7b5_i, imem_ack_i, dmem_ack_i,
    output imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, mdr_we_o, imm_sel_o,
           alu_src_b_o, alu_op_o, wb_sel_o, rf_we_o, pc_we_o, err_o
  );

  // Datapath / memory side.
  modport slave (
    output opcode_i, funct3_i, funct7b5_i, imem_ack_i, dmem_ack_i,
    input  imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, mdr_we_o, imm_sel_o,
           alu_src_b_o, alu_op_o, wb_sel_o, rf_we_o, pc_we_o, err_o
  );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Saturating wait counter for a memory request; expired flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  localparam int unsigned W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count_q;

  assign expired = (count_q == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV64 core: sequences fetch/decode/execute/mem/writeback
// and decodes all datapath enables and memory handshakes from the registered state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  multicycle_ctrl_if.master     bus
);

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;
  err_e       err_q, err_d;
  ctrl_out_t  out_d, out;

  imm_sel_e   imm_sel;
  alu_op_e    alu_op;
  logic       alu_src_b;

  logic       timer_clr, timer_en, timer_expired;

  // NOTE: every register here, including op_q and the sticky error, is reset so the
  // controller restarts from a fully known state after an abandoned transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      op_q    <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Operand/op selects depend only on the latched opcode; shared by EXEC and MEM.
  always_comb begin
    imm_sel   = IMM_I;
    alu_src_b = 1'b1;
    alu_op    = ALU_ADD;
    if (op_q == OP_S) begin
      imm_sel = IMM_S;
    end else if (op_q == OP_R) begin
      imm_sel   = IMM_NONE;
      alu_src_b = 1'b0;
    end
    if ((op_q == OP_I) || (op_q == OP_R)) begin
      alu_op = ALU_FUNCT;
    end
  end

  // NOTE: all outputs of this block get a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    out_d   = '0;

    unique case (state_q)
      FETCH: begin
        out_d.imem_req = 1'b1;
        if (bus.imem_ack_i) begin
          out_d.ir_we = 1'b1;
          state_d     = DECODE;
        end else if (timer_expired) begin
          state_d = TRAP;
          err_d   = ERR_IMEM;
        end
      end

      DECODE: begin
        op_d = bus.opcode_i;
        if (is_legal_op(bus.opcode_i)) begin
          state_d = EXEC;
        end else begin
          state_d = TRAP;
          err_d   = ERR_ILLEGAL;
        end
      end

      EXEC: begin
        out_d.imm_sel   = imm_sel;
        out_d.alu_src_b = alu_src_b;
        out_d.alu_op    = alu_op;
        state_d         = is_mem_op(op_q) ? MEM : WB;
      end

      MEM: begin
        out_d.imm_sel   = imm_sel;
        out_d.alu_src_b = alu_src_b;
        out_d.alu_op    = alu_op;
        out_d.dmem_req  = 1'b1;
        out_d.dmem_we   = (op_q == OP_S);
        if (bus.dmem_ack_i) begin
          if (op_q == OP_S) begin
            out_d.pc_we = 1'b1;
            state_d     = FETCH;
          end else begin
            out_d.mdr_we = 1'b1;
            state_d      = WB;
          end
        end else if (timer_expired) begin
          state_d = TRAP;
          err_d   = ERR_DMEM;
        end
      end

      WB: begin
        out_d.rf_we  = 1'b1;
        out_d.pc_we  = 1'b1;
        out_d.wb_sel = (op_q == OP_L);
        state_d      = FETCH;
      end

      TRAP: begin
        state_d = TRAP;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Any state change clears the timer, which covers entry into FETCH and MEM.
  assign timer_clr = (state_d != state_q);
  assign timer_en  = (out_d.imem_req && !bus.imem_ack_i) ||
                     (out_d.dmem_req && !bus.dmem_ack_i);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Gating with rst_ni makes requests drop the instant reset asserts.
  assign out = rst_ni ? out_d : '0;

  assign bus.imem_req_o  = out.imem_req;
  assign bus.dmem_req_o  = out.dmem_req;
  assign bus.dmem_we_o   = out.dmem_we;
  assign bus.ir_we_o     = out.ir_we;
  assign bus.mdr_we_o    = out.mdr_we;
  assign bus.imm_sel_o   = out.imm_sel;
  assign bus.alu_src_b_o = out.alu_src_b;
  assign bus.alu_op_o    = out.alu_op;
  assign bus.wb_sel_o    = out.wb_sel;
  assign bus.rf_we_o     = out.rf_we;
  assign bus.pc_we_o     = out.pc_we;
  assign bus.err_o       = rst_ni ? err_q : ERR_OK;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction classes, memory waits, timeouts,
// illegal-opcode trap and asynchronous reset in the middle of a load.
module tb_multicycle_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   req_cnt;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .MEM_TIMEOUT (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge, outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] enables();
    return 32'({bus.imem_req_o, bus.dmem_req_o, bus.ir_we_o,
                bus.mdr_we_o, bus.rf_we_o, bus.pc_we_o});
  endfunction

  initial begin
    rst_n          = 1'b0;
    bus.opcode_i   = 7'h00;
    bus.funct3_i   = 3'h0;
    bus.funct7b5_i = 1'b0;
    bus.imem_ack_i = 1'b0;
    bus.dmem_ack_i = 1'b0;

    // ---------------- reset state
    #3;
    check("rst_enables", enables(), 0);
    check("rst_err", 32'(bus.err_o), 0);
    next_cycle();
    check("rst_enables_hold", enables(), 0);

    // ---------------- addi x1,x0,5 (0x00500093), zero-wait imem
    rst_n          = 1'b1;
    bus.imem_ack_i = 1'b1;
    #1;
    check("rel_imem_req", 32'(bus.imem_req_o), 1);
    check("addi_ir_we", 32'(bus.ir_we_o), 1);
    next_cycle();
    bus.imem_ack_i = 1'b0;
    bus.opcode_i   = 7'h13;
    bus.funct3_i   = 3'h0;
    #1;
    check("addi_dec_enables", enables(), 0);
    next_cycle();
    #1;
    check("addi_exec_src_b", 32'(bus.alu_src_b_o), 1);
    check("addi_exec_imm", 32'(bus.imm_sel_o), 0);
    check("addi_exec_aluop", 32'(bus.alu_op_o), 2);
    check("addi_exec_enables", enables(), 0);
    next_cycle();
    #1;
    check("addi_wb_rf_we", 32'(bus.rf_we_o), 1);
    check("addi_wb_pc_we", 32'(bus.pc_we_o), 1);
    check("addi_wb_sel", 32'(bus.wb_sel_o), 0);
    next_cycle();
    #1;
    check("addi_next_fetch", 32'(bus.imem_req_o), 1);

    // ---------------- ld, dmem ack after 3 wait cycles
    bus.imem_ack_i = 1'b1;
    next_cycle();
    bus.imem_ack_i = 1'b0;
    bus.opcode_i   = 7'h03;
    bus.funct3_i   = 3'h3;
    next_cycle();
    #1;
    check("ld_exec_aluop", 32'(bus.alu_op_o), 0);
    check("ld_exec_imm", 32'(bus.imm_sel_o), 0);
    req_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.dmem_ack_i = (i == 3);
      #1;
      req_cnt += int'(bus.dmem_req_o);
      check("ld_dmem_we", 32'(bus.dmem_we_o), 0);
      check("ld_mdr_we", 32'(bus.mdr_we_o), (i == 3) ? 1 : 0);
      check("ld_mem_rf_we", 32'(bus.rf_we_o), 0);
    end
    check("ld_req_cycles", 32'(req_cnt), 4);
    next_cycle();
    bus.dmem_ack_i = 1'b0;
    #1;
    check("ld_wb_rf_we", 32'(bus.rf_we_o), 1);
    check("ld_wb_sel", 32'(bus.wb_sel_o), 1);
    check("ld_wb_no_req", 32'({bus.dmem_req_o, bus.imem_req_o, bus.mdr_we_o}), 0);
    next_cycle();
    #1;
    check("ld_next_fetch", 32'(bus.imem_req_o), 1);

    // ---------------- sd, zero-wait dmem
    bus.imem_ack_i = 1'b1;
    next_cycle();
    bus.imem_ack_i = 1'b0;
    bus.opcode_i   = 7'h23;
    next_cycle();
    #1;
    check("sd_exec_imm", 32'(bus.imm_sel_o), 1);
    check("sd_exec_aluop", 32'(bus.alu_op_o), 0);
    check("sd_exec_rf_we", 32'(bus.rf_we_o), 0);
    next_cycle();
    bus.dmem_ack_i = 1'b1;
    #1;
    check("sd_dmem_req", 32'(bus.dmem_req_o), 1);
    check("sd_dmem_we", 32'(bus.dmem_we_o), 1);
    check("sd_pc_we", 32'(bus.pc_we_o), 1);
    check("sd_mem_imm", 32'(bus.imm_sel_o), 1);
    check("sd_rf_we", 32'(bus.rf_we_o), 0);
    next_cycle();
    bus.dmem_ack_i = 1'b0;
    #1;
    check("sd_next_fetch", 32'(bus.imem_req_o), 1);
    check("sd_fetch_rf_we", 32'(bus.rf_we_o), 0);

    // ---------------- reset pulsed mid-MEM of a load
    bus.imem_ack_i = 1'b1;
    next_cycle();
    bus.imem_ack_i = 1'b0;
    bus.opcode_i   = 7'h03;
    next_cycle();
    next_cycle();
    #1;
    check("rstmem_dmem_req", 32'(bus.dmem_req_o), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmem_req_drop", 32'(bus.dmem_req_o), 0);
    check("rstmem_enables", enables(), 0);
    bus.dmem_ack_i = 1'b1;
    next_cycle();
    #1;
    check("rstmem_enables_ack", enables(), 0);
    bus.dmem_ack_i = 1'b0;
    rst_n          = 1'b1;
    #1;
    check("rstmem_rel_imem_req", 32'(bus.imem_req_o), 1);
    check("rstmem_rel_err", 32'(bus.err_o), 0);

    // ---------------- imem ack arrives in the 16th request cycle: no trap
    req_cnt = 0;
    for (int i = 1; i < 16; i++) begin
      req_cnt += int'(bus.imem_req_o);
      next_cycle();
      #1;
    end
    check("late_ack_req_cycles", 32'(req_cnt), 15);
    bus.imem_ack_i = 1'b1;
    #1;
    check("late_ack_imem_req", 32'(bus.imem_req_o), 1);
    check("late_ack_ir_we", 32'(bus.ir_we_o), 1);
    next_cycle();
    bus.imem_ack_i = 1'b0;
    bus.opcode_i   = 7'h33;
    #1;
    check("late_ack_no_trap_err", 32'(bus.err_o), 0);
    next_cycle();
    #1;
    check("r_exec_src_b", 32'(bus.alu_src_b_o), 0);
    check("r_exec_imm", 32'(bus.imm_sel_o), 2);
    check("r_exec_aluop", 32'(bus.alu_op_o), 2);
    next_cycle();
    #1;
    check("r_wb_rf_we", 32'(bus.rf_we_o), 1);
    check("r_wb_sel", 32'(bus.wb_sel_o), 0);
    next_cycle();
    #1;
    check("r_next_fetch", 32'(bus.imem_req_o), 1);

    // ---------------- imem ack never arrives: trap 16 cycles after req rises
    req_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      req_cnt += int'(bus.imem_req_o);
      if (i == 15) check("imem_to_err_before", 32'(bus.err_o), 0);
      next_cycle();
      #1;
    end
    check("imem_to_req_cycles", 32'(req_cnt), 16);
    check("imem_to_req_drop", 32'(bus.imem_req_o), 0);
    check("imem_to_err", 32'(bus.err_o), 2);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.imem_ack_i = 1'b1;
      bus.dmem_ack_i = 1'b1;
      #1;
      check("imem_trap_enables", enables(), 0);
      check("imem_trap_err_hold", 32'(bus.err_o), 2);
    end
    bus.imem_ack_i = 1'b0;
    bus.dmem_ack_i = 1'b0;

    // ---------------- load with dmem ack never arriving
    rst_n = 1'b0;
    #1;
    check("dmem_rst_err_clear", 32'(bus.err_o), 0);
    next_cycle();
    rst_n          = 1'b1;
    bus.imem_ack_i = 1'b1;
    #1;
    check("dmem_to_ir_we", 32'(bus.ir_we_o), 1);
    next_cycle();
    bus.imem_ack_i = 1'b0;
    bus.opcode_i   = 7'h03;
    next_cycle();
    req_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      #1;
      req_cnt += int'(bus.dmem_req_o);
    end
    check("dmem_to_req_cycles", 32'(req_cnt), 16);
    next_cycle();
    #1;
    check("dmem_to_req_drop", 32'(bus.dmem_req_o), 0);
    check("dmem_to_err", 32'(bus.err_o), 3);

    // ---------------- illegal opcode 1111111
    rst_n = 1'b0;
    next_cycle();
    rst_n          = 1'b1;
    bus.imem_ack_i = 1'b1;
    #1;
    check("ill_fetch_ir_we", 32'(bus.ir_we_o), 1);
    next_cycle();
    bus.imem_ack_i = 1'b0;
    bus.opcode_i   = 7'h7f;
    #1;
    check("ill_dec_err", 32'(bus.err_o), 0);
    next_cycle();
    #1;
    check("ill_trap_err", 32'(bus.err_o), 1);
    check("ill_trap_enables", enables(), 0);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      bus.imem_ack_i = i[0];
      bus.dmem_ack_i = ~i[0];
      #1;
      check("ill_trap_quiet", enables(), 0);
    end
    check("ill_trap_err_hold", 32'(bus.err_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
